// File: rtl/turret_aim_ctrl_pkg.sv
// Shared types, key defaults and the aim table for the turret aiming controller.
// The table entry is (per-frame velocity, spawn pixel) for each aim index.
package turret_pkg;

    typedef struct packed {
        logic [9:0] vx;
        logic [9:0] vy;
        logic [9:0] sx;
        logic [9:0] sy;
    } ang_entry_t;

    // Velocities are two's-complement; 10'h3FE = -2, 10'h3FF = -1.
    localparam ang_entry_t ANG_TBL [0:15] = '{
        '{10'd0,   10'h3FE, 10'd558, 10'd422},
        '{10'h3FF, 10'h3FE, 10'd549, 10'd414},
        '{10'h3FF, 10'h3FF, 10'd550, 10'd415},
        '{10'h3FE, 10'h3FF, 10'd535, 10'd410},
        '{10'h3FE, 10'd0,   10'd510, 10'd420},
        '{10'h3FE, 10'd1,   10'd513, 10'd448},
        '{10'h3FF, 10'd1,   10'd514, 10'd453},
        '{10'h3FF, 10'd2,   10'd516, 10'd455},
        '{10'd0,   10'd2,   10'd545, 10'd458},
        '{10'd0,   10'd0,   10'd0,   10'd0},
        '{10'd0,   10'd0,   10'd0,   10'd0},
        '{10'd0,   10'd0,   10'd0,   10'd0},
        '{10'd0,   10'd0,   10'd0,   10'd0},
        '{10'd0,   10'd0,   10'd0,   10'd0},
        '{10'd0,   10'd0,   10'd0,   10'd0},
        '{10'd0,   10'd0,   10'd0,   10'd0}
    };

    typedef enum logic [1:0] {K_IDLE, K_DELAY, K_REPEAT} key_state_t;
    typedef enum logic [1:0] {F_IDLE, F_VALID, F_COOL} fire_state_t;

    localparam logic [7:0] KEY_CCW_DEF  = 8'h52;
    localparam logic [7:0] KEY_CW_DEF   = 8'h51;
    localparam logic [7:0] KEY_FIRE_DEF = 8'h2C;

endpackage

// File: rtl/turret_aim_ctrl_if.sv
// Fire request handshake between the turret controller and the bullet engine.
// The master raises fire_valid with a held aim snapshot until fire_ready.
interface turret_aim_ctrl_if;
    logic       fire_valid;
    logic       fire_ready;
    logic [9:0] fire_vel_x;
    logic [9:0] fire_vel_y;
    logic [9:0] fire_x;
    logic [9:0] fire_y;

    modport master (
        output fire_valid, fire_vel_x, fire_vel_y, fire_x, fire_y,
        input  fire_ready
    );

    modport slave (
        input  fire_valid, fire_vel_x, fire_vel_y, fire_x, fire_y,
        output fire_ready
    );
endinterface

// File: rtl/turret_aim_ctrl_key_repeat.sv
// Rotation key FSM with press-edge stepping and hold-to-repeat; emits one-cycle
// step_ccw / step_cw pulses.
//   state    | meaning
//   K_IDLE   | no rotation key engaged; a rotation key steps immediately
//   K_DELAY  | key held, waiting out the initial 2*REPEAT_CYCLES delay
//   K_REPEAT | key held, stepping every REPEAT_CYCLES
module turret_key_repeat
    import turret_pkg::*;
#(
    parameter int         REPEAT_CYCLES = 8,
    parameter logic [7:0] KEY_CCW       = KEY_CCW_DEF,
    parameter logic [7:0] KEY_CW        = KEY_CW_DEF
) (
    input  logic       clk2,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       step_ccw,
    output logic       step_cw
);
    localparam int CNT_W = $clog2(2 * REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_DELAY  = CNT_W'(2 * REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_REPEAT = CNT_W'(REPEAT_CYCLES - 1);

    key_state_t       state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             dir, dir_nxt;   // 1 = clockwise
    logic             held_match;

    assign held_match = dir ? (keycode == KEY_CW) : (keycode == KEY_CCW);

    always_ff @(posedge clk2) begin
        if (!Reset) begin
            state <= K_IDLE;
            count <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            dir   <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        dir_nxt   = dir;
        case (state)
            K_IDLE: begin
                if (keycode == KEY_CCW || keycode == KEY_CW) begin
                    dir_nxt   = (keycode == KEY_CW);
                    count_nxt = LOAD_DELAY;
                    state_nxt = K_DELAY;
                end
            end
            K_DELAY, K_REPEAT: begin
                // Releasing or switching keys disengages without stepping.
                if (!held_match) begin
                    count_nxt = '0;
                    state_nxt = K_IDLE;
                end else if (count == '0) begin
                    count_nxt = LOAD_REPEAT;
                    state_nxt = K_REPEAT;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
            default: begin
                count_nxt = '0;
                state_nxt = K_IDLE;
            end
        endcase
    end

    always_comb begin
        step_ccw = 1'b0;
        step_cw  = 1'b0;
        if (state == K_IDLE) begin
            step_ccw = (keycode == KEY_CCW);
            step_cw  = (keycode == KEY_CW);
        end else if (held_match && count == '0) begin
            step_ccw = !dir;
            step_cw  = dir;
        end
    end
endmodule

// File: rtl/turret_aim_ctrl.sv
// Turret aim index, live aim decode and fire request with cooldown.
// Define TURRET_WRAP_EN to wrap the index at both ends instead of saturating.
//   state   | meaning
//   F_IDLE  | ready for a fire press
//   F_VALID | shot offered with held snapshot, waiting for fire_ready
//   F_COOL  | shot accepted, lockout until the cooldown counter empties
module turret_aim_ctrl
    import turret_pkg::*;
#(
    parameter int         N_ANGLES        = 9,
    parameter int         HOME_IDX        = 4,
    parameter int         REPEAT_CYCLES   = 8,
    parameter int         COOLDOWN_CYCLES = 16,
    parameter logic [7:0] KEY_CCW         = KEY_CCW_DEF,
    parameter logic [7:0] KEY_CW          = KEY_CW_DEF,
    parameter logic [7:0] KEY_FIRE        = KEY_FIRE_DEF
) (
    input  logic                        clk2,
    input  logic                        Reset,
    input  logic [7:0]                  keycode,
    output logic [$clog2(N_ANGLES)-1:0] angle_idx,
    output logic [N_ANGLES-1:0]         angle_onehot,
    output logic [9:0]                  vel_x,
    output logic [9:0]                  vel_y,
    output logic [9:0]                  spawn_x,
    output logic [9:0]                  spawn_y,
    output logic                        cooling,
    turret_aim_ctrl_if.master           fire
);
    localparam int IW   = $clog2(N_ANGLES);
    localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(N_ANGLES - 1);
    localparam logic [IW-1:0] IDX_HOME = IW'(HOME_IDX);
`ifdef TURRET_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          step_ccw, step_cw;
    logic [IW-1:0] idx, idx_nxt;
    logic [3:0]    tbl_sel;
    ang_entry_t    cur;

    turret_key_repeat #(
        .REPEAT_CYCLES (REPEAT_CYCLES),
        .KEY_CCW       (KEY_CCW),
        .KEY_CW        (KEY_CW)
    ) u_key (
        .clk2     (clk2),
        .Reset    (Reset),
        .keycode  (keycode),
        .step_ccw (step_ccw),
        .step_cw  (step_cw)
    );

    always_comb begin
        idx_nxt = idx;
        if (step_cw) begin
            if (idx == IDX_MAX) idx_nxt = WRAP ? '0 : idx;
            else                idx_nxt = idx + 1'b1;
        end else if (step_ccw) begin
            if (idx == '0) idx_nxt = WRAP ? IDX_MAX : idx;
            else           idx_nxt = idx - 1'b1;
        end
    end

    always_ff @(posedge clk2) begin
        if (!Reset) idx <= IDX_HOME;
        else        idx <= idx_nxt;
    end

    assign tbl_sel      = 4'(idx);
    assign cur          = ANG_TBL[tbl_sel];
    assign angle_idx    = idx;
    assign angle_onehot = N_ANGLES'(1) << idx;
    assign vel_x        = cur.vx;
    assign vel_y        = cur.vy;
    assign spawn_x      = cur.sx;
    assign spawn_y      = cur.sy;

    fire_state_t     f_state, f_state_nxt;
    logic [7:0]      key_prev;
    logic            fire_edge;
    logic [CD_W-1:0] cool_cnt;
    ang_entry_t      snap;

    assign fire_edge = (keycode == KEY_FIRE) && (key_prev != KEY_FIRE);

    always_ff @(posedge clk2) begin
        if (!Reset) f_state <= F_IDLE;
        else        f_state <= f_state_nxt;
    end

    // Fire presses outside F_IDLE are simply lost, never queued.
    always_comb begin
        f_state_nxt = f_state;
        case (f_state)
            F_IDLE:  if (fire_edge)         f_state_nxt = F_VALID;
            F_VALID: if (fire.fire_ready)   f_state_nxt = F_COOL;
            F_COOL:  if (cool_cnt <= CD_W'(1)) f_state_nxt = F_IDLE;
            default:                        f_state_nxt = F_IDLE;
        endcase
    end

    always_comb begin
        fire.fire_valid = (f_state == F_VALID);
        fire.fire_vel_x = snap.vx;
        fire.fire_vel_y = snap.vy;
        fire.fire_x     = snap.sx;
        fire.fire_y     = snap.sy;
        cooling         = (cool_cnt != '0);
    end

    always_ff @(posedge clk2) begin
        if (!Reset) begin
            key_prev <= 8'h00;
            cool_cnt <= '0;
            snap     <= '0;
        end else begin
            key_prev <= keycode;
            if (f_state == F_IDLE && fire_edge) snap <= cur;
            if (f_state == F_VALID && fire.fire_ready)
                cool_cnt <= CD_W'(COOLDOWN_CYCLES);
            else if (cool_cnt != '0)
                cool_cnt <= cool_cnt - 1'b1;
        end
    end
endmodule
